// File: rtl/mem_dep_wakeup.sv
// rtl/mem_dep_wakeup.sv - load/store indetermination matrix consumer: tracks unresolved older stores per load, issues oldest ready load
module mem_dep_wakeup #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc_valid,
  input  logic [1:0]       alloc_type,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic             resolve_valid,
  input  logic [IDX_W-1:0] resolve_idx,
  output logic             issue_valid,
  output logic [IDX_W-1:0] issue_idx,
  input  logic             issue_ready,
  input  logic             commit_valid
);

  logic [DEPTH-1:0] valid, is_load, resolved, issued;
  logic [DEPTH-1:0] dep [DEPTH];
  logic [IDX_W-1:0] head, tail;
  logic [IDX_W:0]   count;

  logic             alloc_fire, resolve_fire, commit_fire, accept;
  logic             alloc_is_load;
  logic [DEPTH-1:0] cand, new_row;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  assign alloc_ready   = count < (IDX_W+1)'(DEPTH);
  assign alloc_idx     = tail;
  assign alloc_is_load = (alloc_type == 2'b01);
  assign alloc_fire    = alloc_valid & alloc_ready & (alloc_is_load | (alloc_type == 2'b10));
  assign resolve_fire  = resolve_valid & valid[resolve_idx] & ~is_load[resolve_idx];
  assign commit_fire   = commit_valid & valid[head] & (is_load[head] ? issued[head] : resolved[head]);
  assign accept        = issue_valid & issue_ready;

  // The load being accepted this edge is not yet marked issued, so mask it here.
  always_comb begin
    cand    = '0;
    new_row = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = valid[i] & is_load[i] & ~issued[i] & ~(|dep[i]) &
                ~(accept && (issue_idx == IDX_W'(i)));
      new_row[i] = valid[i] & ~is_load[i] & ~resolved[i] &
                   ~(resolve_fire && (resolve_idx == IDX_W'(i))) &
                   (tail != IDX_W'(i));
    end
  end

  // Descending scan so the entry closest to head is the one left standing.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = head;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (cand[head + IDX_W'(k)]) begin
        pick_found = 1'b1;
        pick_idx   = head + IDX_W'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      valid       <= '0;
      is_load     <= '0;
      resolved    <= '0;
      issued      <= '0;
      for (int i = 0; i < DEPTH; i++) dep[i] <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      issue_valid <= 1'b0;
      issue_idx   <= '0;
    end else begin
      if (accept) issued[issue_idx] <= 1'b1;

      if (resolve_fire) begin
        resolved[resolve_idx] <= 1'b1;
        for (int i = 0; i < DEPTH; i++) dep[i][resolve_idx] <= 1'b0;
      end

      if (commit_fire) begin
        valid[head] <= 1'b0;
        for (int i = 0; i < DEPTH; i++) dep[i][head] <= 1'b0;
        head <= head + IDX_W'(1);
      end

      // Row write comes last so it overrides any column clears on the new entry.
      if (alloc_fire) begin
        valid[tail]    <= 1'b1;
        is_load[tail]  <= alloc_is_load;
        resolved[tail] <= 1'b0;
        issued[tail]   <= 1'b0;
        dep[tail]      <= alloc_is_load ? new_row : '0;
        tail           <= tail + IDX_W'(1);
      end

      case ({alloc_fire, commit_fire})
        2'b10:   count <= count + (IDX_W+1)'(1);
        2'b01:   count <= count - (IDX_W+1)'(1);
        default: count <= count;
      endcase

      if (!issue_valid || issue_ready) begin
        issue_valid <= pick_found;
        if (pick_found) issue_idx <= pick_idx;
      end
    end
  end

endmodule

// File: tb/tb_mem_dep_wakeup.sv
// tb/tb_mem_dep_wakeup.sv - scoreboard bench for mem_dep_wakeup against an in-order queue model
module tb_mem_dep_wakeup;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       alloc_valid = 1'b0;
  logic [1:0] alloc_type = 2'b00;
  logic       alloc_ready;
  logic [1:0] alloc_idx;
  logic       resolve_valid = 1'b0;
  logic [1:0] resolve_idx = 2'b00;
  logic       issue_valid;
  logic [1:0] issue_idx;
  logic       issue_ready = 1'b0;
  logic       commit_valid = 1'b0;

  always #5 clk = ~clk;

  mem_dep_wakeup #(.DEPTH(4), .IDX_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_type(alloc_type),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .resolve_valid(resolve_valid), .resolve_idx(resolve_idx),
    .issue_valid(issue_valid), .issue_idx(issue_idx),
    .issue_ready(issue_ready), .commit_valid(commit_valid)
  );

  // Model: program-ordered list of live entries; a load is ready when no
  // older store in the list is still unresolved.
  typedef struct {int slot; bit ld; bit res; bit iss;} ent_t;
  typedef struct {bit ar; int ai; bit iv; int ii;} exp_t;

  ent_t ent[$];
  exp_t expq[$];
  int   m_tail = 0;
  bit   m_iv = 1'b0;
  int   m_ii = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input bit r, input bit fl, input bit av, input int at,
                      input bit rv, input int ri, input bit ir, input bit cv);
    bit acc, cok, aok, blocked;
    int pick, old_ii;
    exp_t e;
    rst = r; flush = fl; alloc_valid = av; alloc_type = at[1:0];
    resolve_valid = rv; resolve_idx = ri[1:0]; issue_ready = ir; commit_valid = cv;
    if (!r || fl) begin
      ent.delete();
      m_tail = 0; m_iv = 1'b0; m_ii = 0;
    end else begin
      acc = m_iv && ir;
      old_ii = m_ii;
      cok = 1'b0;
      if (cv && ent.size() > 0) cok = ent[0].ld ? ent[0].iss : ent[0].res;
      aok = av && (ent.size() < 4) && (at == 1 || at == 2);
      pick = -1; blocked = 1'b0;
      for (int i = 0; i < ent.size(); i++) begin
        if (!ent[i].ld && !ent[i].res) blocked = 1'b1;
        else if (ent[i].ld && !ent[i].iss && !blocked && pick < 0 &&
                 !(acc && ent[i].slot == old_ii)) pick = ent[i].slot;
      end
      if (!m_iv || ir) begin
        m_iv = (pick >= 0);
        if (pick >= 0) m_ii = pick;
      end
      for (int i = 0; i < ent.size(); i++) begin
        if (acc && ent[i].slot == old_ii) ent[i].iss = 1'b1;
        if (rv && ent[i].slot == ri && !ent[i].ld) ent[i].res = 1'b1;
      end
      if (cok) void'(ent.pop_front());
      if (aok) begin
        ent.push_back('{m_tail, (at == 1), 1'b0, 1'b0});
        m_tail = (m_tail + 1) % 4;
      end
    end
    e.ar = (ent.size() < 4); e.ai = m_tail; e.iv = m_iv; e.ii = m_ii;
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ir);
    step(1, 0, 0, 0, 0, 0, ir, 0);
  endtask

  task automatic alloc(input int at);
    step(1, 0, 1, at, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    forever begin
      exp_t e;
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("alloc_ready", int'(alloc_ready), int'(e.ar));
        chk("alloc_idx", int'(alloc_idx), e.ai);
        chk("issue_valid", int'(issue_valid), int'(e.iv));
        if (e.iv) chk("issue_idx", int'(issue_idx), e.ii);
      end
    end
  end

  initial begin : stim
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // single load, zero deps
    alloc(1); idle(0); idle(0); idle(1); idle(0);
    // store then dependent load, woken by resolve
    step(1, 1, 0, 0, 0, 0, 0, 0);
    alloc(2); alloc(1); idle(0); idle(0);
    step(1, 0, 0, 0, 1, 0, 0, 0); idle(0); idle(1); idle(0);
    // two stores, two loads; hold under backpressure
    step(1, 1, 0, 0, 0, 0, 0, 0);
    alloc(2); alloc(2); alloc(1); alloc(1);
    step(1, 0, 0, 0, 1, 1, 0, 0); step(1, 0, 0, 0, 1, 0, 0, 0);
    idle(0); idle(0); idle(0); idle(1); idle(1); idle(0);
    // full queue, ignored alloc, commit + alloc together, blocked commit
    step(1, 1, 0, 0, 0, 0, 0, 0);
    alloc(2); alloc(1); alloc(2); alloc(1); alloc(1);
    step(1, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 2, 0, 0, 0, 1);
    alloc(1); idle(0);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    // invalid alloc type, then flush while offering
    step(1, 0, 1, 3, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    alloc(1); alloc(1); alloc(1); idle(0); idle(0);
    step(1, 1, 0, 0, 0, 0, 0, 0); idle(0);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 6), int'($urandom_range(0, 3)),
           ($urandom_range(0, 9) < 4), int'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 5));
    end
    idle(0);
    repeat (4) @(negedge clk);
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
